// File: rtl/systolic_skew_feeder_if.sv
// Upstream vector stream into the systolic skew feeder: valid/ready beats of
// one ROWS-element column vector, with a last marker travelling alongside.
interface systolic_skew_feeder_if #(
    parameter int DW   = 8,
    parameter int ROWS = 5
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   in_data;
    logic                 in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Feeds a 5x5 weight-stationary systolic array: buffers column vectors in a FIFO and
// drives the rows with a diagonal skew. Define FEEDER_STATS_EN to add the beat_count output.
module systolic_skew_feeder #(
    parameter int DW          = 8,
    parameter int ROWS        = 5,
    parameter int FIFO_DEPTH  = 4,
    parameter int DRAIN_EXTRA = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_skew_feeder_if.slave up,
    input  logic                 start,
    output logic [DW-1:0]        row_data1,
    output logic [DW-1:0]        row_data2,
    output logic [DW-1:0]        row_data3,
    output logic [DW-1:0]        row_data4,
    output logic [DW-1:0]        row_data5,
    output logic [ROWS-1:0]      row_vld,
    output logic                 arr_clear,
    output logic                 busy,
    output logic                 done
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]          beat_count
`endif
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = AW + 1;
    localparam int EW   = ROWS * DW + 1;
    localparam int CW   = $clog2(ROWS + DRAIN_EXTRA);
    localparam logic [CNTW-1:0] DEPTH_C    = CNTW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   DRAIN_LOAD = CW'(ROWS - 1 + DRAIN_EXTRA);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] drain_cnt_q, drain_cnt_d;
    logic arr_clear_q, arr_clear_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            fifo_full, fifo_empty;
    logic            push, pop;
    logic [EW-1:0]   fifo_rd;
    logic            pop_last;
    logic [ROWS*DW-1:0] pop_data;

    assign fifo_full   = (count_q == DEPTH_C);
    assign fifo_empty  = (count_q == '0);
    assign up.in_ready = !fifo_full;
    assign push        = up.in_valid && !fifo_full;
    // Pops only look at the registered count, so a beat written into an empty
    // FIFO becomes poppable one cycle later.
    assign pop         = (state_q == ST_STREAM) && !fifo_empty;
    assign fifo_rd     = fifo_mem[rd_ptr_q];
    assign pop_last    = fifo_rd[EW-1];
    assign pop_data    = fifo_rd[EW-2:0];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {up.in_last, up.in_data};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (pop && pop_last) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                // Leave on the cycle the counter reaches zero, giving exactly
                // DRAIN_LOAD drain cycles after the last pop.
                drain_cnt_d = drain_cnt_q - CW'(1);
                if (drain_cnt_q <= CW'(1)) begin
                    state_d     = ST_DONE;
                    drain_cnt_d = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        arr_clear_d = (state_d == ST_CLEAR);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            arr_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            arr_clear_q <= arr_clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign arr_clear = arr_clear_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Lane gi holds gi+1 registers: the input stage plus gi skew stages. Outside
    // a pop the input stage takes zero data with a zero tag.
    logic [ROWS-1:0][DW-1:0] lane_out;

    genvar gi;
    for (gi = 0; gi < ROWS; gi++) begin : g_lane
        logic [DW-1:0] pipe_q [gi+1];
        logic [DW-1:0] pipe_d [gi+1];
        logic [gi:0]   tag_q, tag_d;

        always_comb begin
            pipe_d[0] = pop ? pop_data[gi*DW +: DW] : '0;
            tag_d[0]  = pop;
            for (int k = 1; k <= gi; k++) begin
                pipe_d[k] = pipe_q[k-1];
                tag_d[k]  = tag_q[k-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= gi; k++) begin
                    pipe_q[k] <= '0;
                end
                tag_q <= '0;
            end else begin
                pipe_q <= pipe_d;
                tag_q  <= tag_d;
            end
        end

        assign lane_out[gi] = pipe_q[gi];
        assign row_vld[gi]  = tag_q[gi];
    end

    assign row_data1 = lane_out[0];
    assign row_data2 = lane_out[1];
    assign row_data3 = lane_out[2];
    assign row_data4 = lane_out[3];
    assign row_data5 = lane_out[4];

`ifdef FEEDER_STATS_EN
    logic [15:0] beat_count_q, beat_count_d;

    always_comb begin
        beat_count_d = beat_count_q;
        if (state_d == ST_CLEAR) begin
            beat_count_d = '0;
        end else if (push && (beat_count_q != 16'hFFFF)) begin
            beat_count_d = beat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count_q <= '0;
        end else begin
            beat_count_q <= beat_count_d;
        end
    end

    assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: a queue/window model checked every cycle,
// plus hand-computed timing and dot-product expectations.
module tb_systolic_skew_feeder;
    localparam int DW   = 8;
    localparam int ROWS = 5;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.DW(DW), .ROWS(ROWS)) feed_if ();

    logic [DW-1:0]   row_data1, row_data2, row_data3, row_data4, row_data5;
    logic [ROWS-1:0] row_vld;
    logic            arr_clear, busy, done;
`ifdef FEEDER_STATS_EN
    logic [15:0]     beat_count;
`endif

    systolic_skew_feeder #(.DW(DW), .ROWS(ROWS), .FIFO_DEPTH(4), .DRAIN_EXTRA(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .up        (feed_if),
        .start     (start),
        .row_data1 (row_data1),
        .row_data2 (row_data2),
        .row_data3 (row_data3),
        .row_data4 (row_data4),
        .row_data5 (row_data5),
        .row_vld   (row_vld),
        .arr_clear (arr_clear),
        .busy      (busy),
`ifdef FEEDER_STATS_EN
        .beat_count(beat_count),
`endif
        .done      (done)
    );

    logic [7:0] rows_dut [1:5];
    assign rows_dut[1] = row_data1;
    assign rows_dut[2] = row_data2;
    assign rows_dut[3] = row_data3;
    assign rows_dut[4] = row_data4;
    assign rows_dut[5] = row_data5;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int acc      = 0;
    int n_done   = 0;
    int n_clear  = 0;
    int n_row1   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: FIFO as a queue, stream phase, and a window of the last
    // five injected vectors; row r shows lane r of the vector injected r edges ago.
    typedef enum int {M_IDLE, M_CLEAR, M_STREAM, M_DRAIN, M_DONE} mphase_t;
    logic [40:0] mq [$];
    mphase_t     m_phase = M_IDLE;
    int          m_drain = 0;
    logic [7:0]  win_d [1:5][1:5];
    bit          win_t [1:5];
    int unsigned m_beats = 0;

    task automatic m_reset();
        mq.delete();
        m_phase = M_IDLE;
        m_drain = 0;
        m_beats = 0;
        for (int k = 1; k <= 5; k++) begin
            win_t[k] = 1'b0;
            for (int l = 1; l <= 5; l++) win_d[k][l] = 8'h00;
        end
    endtask

    task automatic m_step();
        bit          push = feed_if.in_valid && (mq.size() < 4);
        logic [40:0] ent  = {feed_if.in_last, feed_if.in_data};
        bit          popped = 1'b0;
        logic [40:0] pe = '0;
        if (m_phase == M_STREAM && mq.size() > 0) begin
            pe = mq.pop_front();
            popped = 1'b1;
        end
        if (push) mq.push_back(ent);
        for (int k = 5; k >= 2; k--) begin
            win_t[k] = win_t[k-1];
            for (int l = 1; l <= 5; l++) win_d[k][l] = win_d[k-1][l];
        end
        win_t[1] = popped;
        for (int l = 1; l <= 5; l++) win_d[1][l] = pe[(l-1)*8 +: 8];
        case (m_phase)
            M_IDLE:   if (start) m_phase = M_CLEAR;
            M_CLEAR:  m_phase = M_STREAM;
            M_STREAM: if (popped && pe[40]) begin m_phase = M_DRAIN; m_drain = 4 + 5; end
            M_DRAIN:  begin m_drain--; if (m_drain == 0) m_phase = M_DONE; end
            default:  m_phase = M_IDLE;
        endcase
        if (m_phase == M_CLEAR) m_beats = 0;
        else if (push && m_beats != 32'hFFFF) m_beats++;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                logic [4:0] ev;
                for (int r = 1; r <= 5; r++) begin
                    ev[r-1] = win_t[r];
                    chk($sformatf("row_data%0d", r), rows_dut[r], win_d[r][r]);
                    if (row_vld[r-1]) acc += int'(rows_dut[r]) * r;
                end
                chk("row_vld", row_vld, ev);
                chk("arr_clear", arr_clear, m_phase == M_CLEAR);
                chk("busy", busy, m_phase != M_IDLE);
                chk("done", done, m_phase == M_DONE);
                chk("in_ready", feed_if.in_ready, mq.size() < 4);
`ifdef FEEDER_STATS_EN
                chk("beat_count", beat_count, m_beats);
`endif
                n_done  += int'(done);
                n_clear += int'(arr_clear);
                n_row1  += int'(row_vld[0]);
            end
        end
    end

    function automatic logic [39:0] mk(input int b);
        return {8'(b + 4), 8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send(input logic [39:0] d, input logic l, input int gap);
        int n = 0;
        feed_if.in_valid = 1'b1;
        feed_if.in_data  = d;
        feed_if.in_last  = l;
        while (!feed_if.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", feed_if.in_ready, 1'b1);
        @(negedge clk);
        $display("[%0t] beat %h last=%0b", $time, d, l);
        feed_if.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_done, b_clear, b_row1;
        feed_if.in_valid = 1'b0;
        feed_if.in_data  = '0;
        feed_if.in_last  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", feed_if.in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_row_vld", row_vld, 5'b0);
        chk("rst_row_data5", row_data5, 8'h00);
        chk("rst_arr_clear", arr_clear, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Single vector preloaded in IDLE
        send(40'h0504030201, 1'b1, 0);
        chk("preload_busy", busy, 1'b0);
        acc = 0;
        pulse_start();
        chk("single_clear", arr_clear, 1'b1);
        for (int k = 2; k <= 13; k++) begin
            @(negedge clk);
            if (k == 2) chk("single_clear_off", arr_clear, 1'b0);
            if (k == 3) begin chk("single_row1", row_data1, 8'd1); chk("single_vld_k3", row_vld, 5'b00001); end
            if (k == 4) begin chk("single_row2", row_data2, 8'd2); chk("single_vld_k4", row_vld, 5'b00010); end
            if (k == 7) begin chk("single_row5", row_data5, 8'd5); chk("single_vld_k7", row_vld, 5'b10000); end
            if (k == 8) chk("single_vld_k8", row_vld, 5'b00000);
            if (k == 11) chk("single_done_early", done, 1'b0);
            if (k == 12) chk("single_done", done, 1'b1);
            if (k == 13) chk("single_idle", busy, 1'b0);
        end
        @(negedge clk);
        chk("single_dot55", acc, 55);

        // Backpressure: six vectors with no start, then start
        b_row1 = n_row1;
        fork
            begin
                for (int i = 0; i < 6; i++) send(mk(10 * i + 10), i == 5, 0);
            end
            begin
                repeat (8) @(negedge clk);
                chk("bp_ready_low", feed_if.in_ready, 1'b0);
                chk("bp_busy_idle", busy, 1'b0);
                pulse_start();
            end
        join
        wait_done();
        chk("bp_row1_beats", n_row1 - b_row1, 6);

        // Bubbles: vectors on alternate cycles during STREAM
        b_row1 = n_row1;
        pulse_start();
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(mk(100 + 5 * i), i == 3, 1);
        wait_done();
        chk("bub_row1_beats", n_row1 - b_row1, 4);

        // Start during DRAIN is ignored
        send(mk(200), 1'b1, 0);
        pulse_start();
        repeat (2) @(negedge clk);
        b_clear = n_clear;
        b_done  = n_done;
        pulse_start();
        wait_done();
        chk("ign_no_clear", n_clear - b_clear, 0);
        chk("ign_one_done", n_done - b_done, 1);
        chk("ign_idle", busy, 1'b0);

`ifdef FEEDER_STATS_EN
        pulse_start();
        for (int i = 0; i < 3; i++) send(mk(30 + i), i == 2, 0);
        wait_done();
        chk("stats_three", beat_count, 16'd3);
        pulse_start();
        chk("stats_clear", beat_count, 16'd0);
        send(mk(60), 1'b1, 0);
        wait_done();
`endif

        // Asynchronous reset mid-stream
        pulse_start();
        for (int i = 0; i < 3; i++) send(mk(150 + i), 1'b0, 0);
        @(negedge clk);
        chk("prerst_rows_live", row_vld != 5'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_row1", row_data1, 8'h00);
        chk("arst_row2", row_data2, 8'h00);
        chk("arst_row3", row_data3, 8'h00);
        chk("arst_row_vld", row_vld, 5'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_in_ready", feed_if.in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("postrst_idle", busy, 1'b0);
        send(40'h0504030201, 1'b1, 0);
        acc = 0;
        pulse_start();
        wait_done();
        repeat (4) @(negedge clk);
        chk("postrst_dot55", acc, 55);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream feeder for the 5x5 weight-stationary systolic array.
- Accepts one 5-element column vector per beat over a valid/ready handshake and buffers vectors in a small FIFO.
- Drives the array's five 8-bit row inputs with a diagonal skew: row r is delayed r-1 cycles, so partial sums moving down each column meet the matching operand.
- Sequences end-of-stream draining and the array clear pulse.

Parameters:
- DW, 8, operand width per row; matches array row input width.
- ROWS, 5, number of array rows/skew lanes; fixed array size, RTL need only support 5.
- FIFO_DEPTH, 4, input vector FIFO entries; power of two, min 2.
- DRAIN_EXTRA, 5, extra zero cycles after the skew flush, covering the array's column pipeline.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  upstream vector valid
- in_ready  out  1  FIFO can accept a vector
- in_data  in  ROWS*DW  vector; row r at bits [r*DW-1:(r-1)*DW], r=1..ROWS
- in_last  in  1  marks final vector of a stream; sampled with the beat
- start  in  1  one-cycle pulse; begin a stream (IDLE only)
- row_data1..row_data5  out  DW each  to array data_in1..data_in5
- row_vld  out  ROWS  per-row tag: row_dataN carries a real operand
- arr_clear  out  1  to array clear
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when stream fully drained

Behaviour:
- Reset (async): FIFO empty; state IDLE; all skew regs 0; row_data*=0, row_vld=0, arr_clear=0, done=0, busy=0, in_ready=1.
- Handshake: a beat is accepted iff in_valid & in_ready at a rising edge. in_ready = !fifo_full; it is independent of state, so vectors may be preloaded in IDLE. Data is never dropped or duplicated.
- FIFO: synchronous, FIFO_DEPTH entries of {in_last, in_data}. Simultaneous push+pop when full is not allowed (in_ready=0); when empty, a push is not visible to pop until the next cycle (1-cycle fall-through latency).
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
  - IDLE: start -> CLEAR. start in any other state is ignored.
  - CLEAR: arr_clear=1 for exactly one cycle -> STREAM.
  - STREAM: each cycle, if FIFO non-empty, pop one vector into the skew input stage with tag=1; else inject zeros with tag=0 (bubble). A pop whose stored last bit is 1 -> DRAIN and loads drain counter = (ROWS-1)+DRAIN_EXTRA.
  - DRAIN: inject zeros (tag=0) and decrement the counter; no pops. Counter==0 -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Skew: the lane-r input stage is the popped/injected element r. row_datar/row_vld[r-1] equal that element delayed r cycles total (1 input register + r-1 skew stages). Row1 latency from pop = 1 cycle; row5 = 5 cycles.
- Outside STREAM/DRAIN, skew stages shift in zeros with tag 0, so outputs settle to 0 within ROWS cycles.
- Zero injection: bubbles carry data 0 so that w*0 adds nothing to partial sums.
- Mid-stream reset: all state is lost immediately; outputs are 0 asynchronously.
- arr_clear is registered; it never coincides with row_vld=1 on row 1.

Optional Feature:
- Macro FEEDER_STATS_EN.
- Defined: adds output beat_count (16 bits). It counts accepted input beats since the last CLEAR state, is cleared in CLEAR and by rst, and saturates at 16'hFFFF.
- Undefined: no port, no counter logic.

Test Plan:
- Reset: assert rst mid-STREAM with rows holding data -> all row_data*=0, row_vld=0, busy=0, in_ready=1 in the same cycle; after release the state is IDLE.
- Single vector: preload {5,4,3,2,1} (row1=1..row5=5) with in_last=1, pulse start -> arr_clear high 1 cycle. Then row_data1=1 one cycle after the pop, row_data2=2 at +2, ... row_data5=5 at +5, each with its row_vld bit set for exactly one cycle. done fires after 4+5 drain cycles; wired to the array, the column-1 output is 1*1+2*2+3*3+4*4+5*5=55.
- Backpressure: hold in_valid=1 with 6 vectors and no start -> in_ready drops after 4 accepts. Pulse start -> the remaining 2 are accepted as space frees; all 6 emerge in order, none lost.
- Bubbles: in STREAM, present vectors on alternate cycles -> tagged 0-data bubbles interleave; row_vld patterns per lane are shifted diagonally by 1 cycle per row.
- Ignored start: pulse start during DRAIN -> no arr_clear, no state change; done still fires once.
- FEEDER_STATS_EN: stream 3 vectors -> beat_count=3 after done; the next start resets it to 0 on the CLEAR cycle.
